// File: rtl/cu_pkg.sv
// Shared control-unit types: instruction register layout and fetch FSM states.
package cu_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
  } ir_t;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam int PC_W  = 16;
  localparam int IR_W  = 32;
  localparam int ENT_W = IR_W + PC_W;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {instruction, pc} entries with occupancy count and flush.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, credit-limited memory requests, prefetch buffer and redirect handling.
module instr_fetch
  import cu_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output ir_t         ir,
  output logic [15:0] ir_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic              outstanding_q;
  logic              run_q;
  logic [CW-1:0]     count;
  logic              credit, accept, push, pop;
  logic [ENT_W-1:0]  head;

  // run_q keeps the request line quiet until the first edge after reset release.
  assign credit   = (count + CW'(outstanding_q)) < CW'(DEPTH);
  assign mem_req  = run_q && (outstanding_q || ((state_q == FETCH) && credit));
  assign mem_addr = fetch_pc_q;
  assign accept   = mem_req && mem_ack;
  assign ir_valid = (count != '0);
  assign pop      = ir_valid && ir_ready;
  assign ir       = ir_t'(head[ENT_W-1:PC_W]);
  assign ir_pc    = head[PC_W-1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    push       = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (mem_req && !mem_ack) begin
            state_d  = DRAIN;
            target_d = redirect_pc;
          end else begin
            fetch_pc_d = redirect_pc;
          end
        end else if (accept) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 16'd1;
        end
      end
      DRAIN: begin
        // The stale request completes here; its data is discarded.
        if (redirect_valid) target_d = redirect_pc;
        if (accept) begin
          state_d    = FETCH;
          fetch_pc_d = redirect_valid ? redirect_pc : target_q;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      target_q      <= '0;
      outstanding_q <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      target_q      <= target_d;
      outstanding_q <= mem_req && !mem_ack;
      run_q         <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  ({mem_rdata, mem_addr}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

endmodule
